tq_row_seq: RTL and testbench

Row sequencer for the 2D transform datapath in the rec_tq pipeline. It sits directly upstream of the valid-routing stage. For each transform block it emits one registered row-valid per 1D row operation, in two passes: first pass across rows, then across transposed columns. It holds the block's inverse flag stable for the whole block, so the downstream router steers every valid of the block to the same mux (forward → mux1, inverse → mux3). It also supplies row index, pass and first/last markers to the datapath and transpose buffer.

---
 rtl/tq_row_seq_if.sv | 29 ++
 rtl/tq_row_seq.sv | 124 ++++++++++++
 tb/tb_tq_row_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/tq_row_seq_if.sv
// Handshake and row-control bundle between the rec_tq front end and the row sequencer.
// The master drives the i_* requests; the sequencer (slave) drives the registered o_* outputs.
interface tq_row_seq_if;
    logic       i_start;
    logic [1:0] i_size;
    logic       i_inverse;
    logic       i_row_valid;
    logic       i_stall;
    logic       o_ready;
    logic       o_valid;
    logic       o_inverse;
    logic       o_pass;
    logic [4:0] o_row_idx;
    logic       o_first_row;
    logic       o_last_row;
    logic       o_done;

    modport master (
        output i_start, i_size, i_inverse, i_row_valid, i_stall,
        input  o_ready, o_valid, o_inverse, o_pass, o_row_idx,
               o_first_row, o_last_row, o_done
    );

    modport slave (
        input  i_start, i_size, i_inverse, i_row_valid, i_stall,
        output o_ready, o_valid, o_inverse, o_pass, o_row_idx,
               o_first_row, o_last_row, o_done
    );
endinterface

// File: rtl/tq_row_seq.sv
// Two-pass row sequencer for the 2D transform: issues N row valids across rows, waits
// GAP_CYC cycles for transpose turnaround, then N valids across columns, holding the inverse flag.
module tq_row_seq #(
    parameter int GAP_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    tq_row_seq_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PASS1 = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_PASS2 = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] GAP_INIT = 3'(GAP_CYC);

    logic [2:0] r_state;
    logic [1:0] r_size;
    logic [4:0] r_cnt;
    logic [2:0] r_gap;
    logic       r_ready;
    logic       r_valid;
    logic       r_inverse;
    logic       r_pass;
    logic [4:0] r_row_idx;
    logic       r_first;
    logic       r_last;
    logic       r_done;

    logic [5:0] w_n;
    logic [4:0] w_last_idx;
    logic       w_issue;
    logic       w_at_last;

    assign w_n        = 6'd4 << r_size;
    assign w_last_idx = 5'(w_n - 6'd1);
    assign w_at_last  = (r_cnt == w_last_idx);
    assign w_issue    = ((r_state == S_PASS1) && bus.i_row_valid) ||
                        ((r_state == S_PASS2) && !bus.i_stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_size    <= 2'd0;
            r_cnt     <= 5'd0;
            r_gap     <= 3'd0;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_inverse <= 1'b0;
            r_pass    <= 1'b0;
            r_row_idx <= 5'd0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_valid <= w_issue;
            r_first <= w_issue && (r_cnt == 5'd0);
            r_last  <= w_issue && w_at_last;
            r_done  <= 1'b0;
            if (w_issue) begin
                r_pass    <= (r_state == S_PASS2);
                r_row_idx <= r_cnt;
            end

            case (r_state)
                S_IDLE: begin
                    // Ready is re-armed one cycle after done, so a start is only taken once o_ready is seen high.
                    if (r_ready && bus.i_start) begin
                        r_size    <= bus.i_size;
                        r_inverse <= bus.i_inverse;
                        r_cnt     <= 5'd0;
                        r_ready   <= 1'b0;
                        r_state   <= S_PASS1;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_PASS1: begin
                    if (bus.i_row_valid) begin
                        if (w_at_last) begin
                            r_cnt   <= 5'd0;
                            r_gap   <= GAP_INIT;
                            r_state <= S_GAP;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap - 3'd1;
                    if (r_gap == 3'd1) begin
                        r_state <= S_PASS2;
                    end
                end
                S_PASS2: begin
                    if (!bus.i_stall) begin
                        if (w_at_last) begin
                            r_cnt   <= 5'd0;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready     = r_ready;
    assign bus.o_valid     = r_valid;
    assign bus.o_inverse   = r_inverse;
    assign bus.o_pass      = r_pass;
    assign bus.o_row_idx   = r_row_idx;
    assign bus.o_first_row = r_first;
    assign bus.o_last_row  = r_last;
    assign bus.o_done      = r_done;
endmodule

// File: tb/tb_tq_row_seq.sv
// Bench for tq_row_seq: two instances (GAP_CYC=2 and GAP_CYC=7) share one stimulus stream;
// each block's expected timeline is derived from the issue/gap/stall rules as edge lists.
module tb_tq_row_seq;
    localparam int MAXE = 512;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] size;
    logic       inverse;
    logic       row_valid;
    logic       stall;

    tq_row_seq_if bus2 ();
    tq_row_seq_if bus7 ();

    assign bus2.i_start = start;     assign bus7.i_start = start;
    assign bus2.i_size = size;       assign bus7.i_size = size;
    assign bus2.i_inverse = inverse; assign bus7.i_inverse = inverse;
    assign bus2.i_row_valid = row_valid; assign bus7.i_row_valid = row_valid;
    assign bus2.i_stall = stall;     assign bus7.i_stall = stall;

    tq_row_seq #(.GAP_CYC(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    tq_row_seq #(.GAP_CYC(7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

    logic       o_ready[2], o_valid[2], o_inv[2], o_pass[2], o_first[2], o_last[2], o_done[2];
    logic [4:0] o_idx[2];
    assign o_ready[0] = bus2.o_ready;     assign o_ready[1] = bus7.o_ready;
    assign o_valid[0] = bus2.o_valid;     assign o_valid[1] = bus7.o_valid;
    assign o_inv[0]   = bus2.o_inverse;   assign o_inv[1]   = bus7.o_inverse;
    assign o_pass[0]  = bus2.o_pass;      assign o_pass[1]  = bus7.o_pass;
    assign o_first[0] = bus2.o_first_row; assign o_first[1] = bus7.o_first_row;
    assign o_last[0]  = bus2.o_last_row;  assign o_last[1]  = bus7.o_last_row;
    assign o_done[0]  = bus2.o_done;      assign o_done[1]  = bus7.o_done;
    assign o_idx[0]   = bus2.o_row_idx;   assign o_idx[1]   = bus7.o_row_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus per edge (edge 0 samples the start) and expected outputs sampled after each edge.
    bit   rvs[MAXE];
    bit   sts[MAXE];
    logic ev[2][MAXE];
    logic ep[2][MAXE];
    logic ed[2][MAXE];
    logic er[2][MAXE];
    int   ei[2][MAXE];
    int   p2e[2][32];
    int   last_p2[2];
    int   obs_done[2];
    int   obs_last_p1[2];
    int   obs_first_p2[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int k);
        chk($sformatf("rst_ready[%0d]", k), 32'(o_ready[k]), 1);
        chk($sformatf("rst_valid[%0d]", k), 32'(o_valid[k]), 0);
        chk($sformatf("rst_inv[%0d]", k),   32'(o_inv[k]),   0);
        chk($sformatf("rst_pass[%0d]", k),  32'(o_pass[k]),  0);
        chk($sformatf("rst_idx[%0d]", k),   32'(o_idx[k]),   0);
        chk($sformatf("rst_first[%0d]", k), 32'(o_first[k]), 0);
        chk($sformatf("rst_last[%0d]", k),  32'(o_last[k]),  0);
        chk($sformatf("rst_done[%0d]", k),  32'(o_done[k]),  0);
    endtask

    // mode 0: row_valid=1, stall=0; 1: row_valid toggles 1,0; 2: stall window edges 14..18; 3: random
    task automatic fill_stim(input int mode);
        for (int e = 0; e < MAXE; e++) begin
            case (mode)
                0: begin rvs[e] = 1'b1; sts[e] = 1'b0; end
                1: begin rvs[e] = (e % 2 == 1); sts[e] = 1'b0; end
                2: begin rvs[e] = 1'b1; sts[e] = (e >= 14 && e <= 18); end
                default: begin rvs[e] = 1'($urandom); sts[e] = ($urandom_range(0, 2) == 0); end
            endcase
        end
    endtask

    // Expected timeline: first N row_valid edges after start, then after the gap the first N unstalled edges.
    task automatic build_model(input int k, input int g, input int n);
        int cnt;
        int e;
        int lp1;
        for (int i = 0; i < MAXE; i++) begin
            ev[k][i] = 1'b0; ep[k][i] = 1'b0; ed[k][i] = 1'b0; ei[k][i] = 0;
        end
        cnt = 0; e = 1; lp1 = 1;
        while (cnt < n && e < MAXE - 40) begin
            if (rvs[e]) begin
                ev[k][e] = 1'b1; ep[k][e] = 1'b0; ei[k][e] = cnt; cnt++; lp1 = e;
            end
            e++;
        end
        cnt = 0; e = lp1 + g + 1; last_p2[k] = e;
        while (cnt < n && e < MAXE - 4) begin
            if (!sts[e]) begin
                ev[k][e] = 1'b1; ep[k][e] = 1'b1; ei[k][e] = cnt; p2e[k][cnt] = e;
                cnt++; last_p2[k] = e;
            end
            e++;
        end
        ed[k][last_p2[k] + 1] = 1'b1;
        for (int i = 0; i < MAXE; i++) er[k][i] = (i >= last_p2[k] + 2);
    endtask

    task automatic run_block(input logic [1:0] sz, input logic inv, input int mode,
                             input bit bad_start, input bit abort);
        int n;
        int lmin;
        int lmax;
        int abort_e;
        n = 4 << sz;
        fill_stim(mode);
        build_model(0, 2, n);
        build_model(1, 7, n);
        lmin = (last_p2[0] < last_p2[1]) ? last_p2[0] : last_p2[1];
        lmax = (last_p2[0] > last_p2[1]) ? last_p2[0] : last_p2[1];
        abort_e = abort ? p2e[0][5] : -1;
        for (int k = 0; k < 2; k++) begin
            obs_done[k] = -1; obs_last_p1[k] = -1; obs_first_p2[k] = -1;
        end
        start = 1'b1; size = sz; inverse = inv; row_valid = rvs[0]; stall = sts[0];
        for (int e = 0; e <= lmax + 2; e++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("valid[%0d]@%0d", k, e), 32'(o_valid[k]), 32'(ev[k][e]));
                if (ev[k][e]) begin
                    chk($sformatf("pass[%0d]@%0d", k, e), 32'(o_pass[k]), 32'(ep[k][e]));
                    chk($sformatf("idx[%0d]@%0d", k, e), 32'(o_idx[k]), 32'(ei[k][e]));
                end
                chk($sformatf("first[%0d]@%0d", k, e), 32'(o_first[k]), 32'(ev[k][e] && ei[k][e] == 0));
                chk($sformatf("last[%0d]@%0d", k, e), 32'(o_last[k]), 32'(ev[k][e] && ei[k][e] == n - 1));
                chk($sformatf("done[%0d]@%0d", k, e), 32'(o_done[k]), 32'(ed[k][e]));
                chk($sformatf("ready[%0d]@%0d", k, e), 32'(o_ready[k]), 32'(er[k][e]));
                chk($sformatf("inv[%0d]@%0d", k, e), 32'(o_inv[k]), 32'(inv));
                if (o_done[k] && obs_done[k] < 0) obs_done[k] = e;
                if (o_valid[k] && !o_pass[k]) obs_last_p1[k] = e;
                if (o_valid[k] && o_pass[k] && obs_first_p2[k] < 0) obs_first_p2[k] = e;
            end
            if (e == abort_e) begin
                rst = 1'b1; start = 1'b0;
                #1;
                chk_reset(0);
                chk_reset(1);
                @(negedge clk);
                rst = 1'b0;
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk); #1;
                    for (int k = 0; k < 2; k++) begin
                        chk($sformatf("post_rst_valid[%0d]@%0d", k, c), 32'(o_valid[k]), 0);
                        chk($sformatf("post_rst_done[%0d]@%0d", k, c), 32'(o_done[k]), 0);
                        chk($sformatf("post_rst_ready[%0d]@%0d", k, c), 32'(o_ready[k]), 1);
                    end
                end
                break;
            end
            // Stray starts with random size/inverse while both instances are busy must be ignored.
            start   = (e + 1 <= lmin + 1) && ($urandom_range(0, 3) == 0);
            size    = 2'($urandom);
            inverse = 1'($urandom);
            if (bad_start && e + 1 == 2) begin
                start = 1'b1; size = 2'd3; inverse = ~inv;
            end
            row_valid = rvs[e + 1];
            stall     = sts[e + 1];
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; size = 2'd0; inverse = 1'b0; row_valid = 1'b0; stall = 1'b0;
        #2;
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_block(2'd0, 1'b0, 0, 1'b0, 1'b0);
        chk("fwd4_done_lat_g2", 32'(obs_done[0]), 11);
        chk("fwd4_done_lat_g7", 32'(obs_done[1]), 16);

        run_block(2'd3, 1'b1, 1, 1'b0, 1'b0);

        run_block(2'd1, 1'b0, 2, 1'b0, 1'b0);
        chk("stall8_done_lat_g2", 32'(obs_done[0]), 24);

        run_block(2'd0, 1'b1, 0, 1'b1, 1'b0);
        chk("badstart4_done_g2", 32'(obs_done[0]), 11);

        run_block(2'd0, 1'b0, 0, 1'b0, 1'b0);

        run_block(2'd2, 1'b1, 0, 1'b0, 1'b1);

        run_block(2'd0, 1'b0, 0, 1'b0, 1'b0);
        chk("after_rst4_done_g2", 32'(obs_done[0]), 11);

        run_block(2'd1, 1'b0, 0, 1'b0, 1'b0);
        chk("gap7_p1_to_p2", 32'(obs_first_p2[1] - obs_last_p1[1]), 8);
        chk("gap2_p1_to_p2", 32'(obs_first_p2[0] - obs_last_p1[0]), 3);

        for (int b = 0; b < 4; b++) begin
            run_block(2'($urandom), 1'($urandom), 3, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
